mem_debug_arbiter: RTL
======================

# mem_debug_arbiter

Shares the single 16-bit memory port between the multi-cycle CPU core and the host debug/test port. Debug reads and writes are granted only at an instruction boundary, when the CPU sits in its fetch state. The CPU is frozen with `cpu_hold` for the duration of each debug access. Debug accesses use a four-phase req/ack handshake, and a bounded wait reports an error if the CPU never reaches a boundary.

## Interface

Parameters:
- `MEM_LATENCY`, 1: cycles from read address to valid `mem_rdata`; legal range 1..4.
- `TIMEOUT`, 1023: maximum cycles spent waiting for `cpu_boundary` before an error ack.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; 0 forces the reset state immediately.
- `cpu_boundary` in 1: CPU is in its fetch state (state 1).
- `cpu_mem_addr` in 16: CPU memory address.
- `cpu_mem_wdata` in 16: CPU write data.
- `cpu_mem_we` in 1: CPU write enable.
- `cpu_hold` out 1: freezes the CPU state register, PC, SP and IR.
- `dbg_req` in 1: debug request; held high until `dbg_ack` is seen.
- `dbg_we` in 1: 1 = write, 0 = read; stable while `dbg_req` is high.
- `dbg_addr` in 16: debug address.
- `dbg_wdata` in 16: debug write data.
- `dbg_ack` out 1: access complete; held until `dbg_req` falls.
- `dbg_err` out 1: valid with `dbg_ack`; 1 = timeout, no access performed.
- `dbg_rdata` out 16: read result, valid with `dbg_ack` when `dbg_we` = 0.
- `mem_addr` out 16: to memory.
- `mem_wdata` out 16: to memory.
- `mem_we` out 1: to memory.
- `mem_rdata` in 16: from memory.

## Operation

- **States:** IDLE, WAIT_BND, ACCESS, WAIT_DATA, ACK.
- **IDLE**
  - `dbg_req` & `cpu_boundary`: latch `dbg_addr`/`dbg_wdata`/`dbg_we`, go to ACCESS.
  - `dbg_req` & !`cpu_boundary`: go to WAIT_BND and clear the timeout counter.
- **WAIT_BND**
  - `cpu_boundary`: latch the request, go to ACCESS.
  - `dbg_req` falls: go to IDLE with no ack and no access.
  - Counter reaches `TIMEOUT`-1: go to ACK with `dbg_err`=1.
  - Otherwise increment the counter.
- **ACCESS**
  - Memory port is driven from the latched debug fields.
  - Write: `mem_we`=1 for exactly this cycle, then go to ACK.
  - Read: go to WAIT_DATA.
- **WAIT_DATA**: count `MEM_LATENCY` cycles from ACCESS, capture `mem_rdata` into `dbg_rdata`, go to ACK.
- **ACK**
  - `dbg_ack`=1; `dbg_err` reflects timeout.
  - Wait for `dbg_req`=0, then go to IDLE and clear `dbg_ack`/`dbg_err`.
- **`cpu_hold`** is combinational:
  - 1 in ACCESS, WAIT_DATA and ACK, except an ACK reached by timeout.
  - 1 in IDLE/WAIT_BND when `dbg_req` & `cpu_boundary`, so the CPU never leaves fetch on the granting edge.
  - Forced to 0 while `reset`=0.
- **Memory mux:** in IDLE/WAIT_BND, and in a timeout ACK, `mem_*` mirror the `cpu_mem_*` inputs. In ACCESS, WAIT_DATA and a normal ACK they carry the latched debug address/data, with `mem_we`=0 outside ACCESS.
- **Counter width:** $clog2(`TIMEOUT`+1); it saturates and does not wrap.
- **Writes** leave `dbg_rdata` unchanged.

## Timing

- **Reset values:** state IDLE, `dbg_ack`=0, `dbg_err`=0, `dbg_rdata`=0x0000, counter 0, `cpu_hold`=0. `mem_*` follow the CPU inputs.
- **Latency with the CPU already at a boundary:**
  - Write: ack 2 edges after `dbg_req` is sampled.
  - Read: ack 2+`MEM_LATENCY` edges after `dbg_req` is sampled.
- **Back-to-back requests:** `dbg_req` must be low for at least 1 cycle between requests. Each request re-arbitrates at a boundary; the CPU resumes for at least 1 cycle only if it is not at a boundary.
- **`dbg_req` rising in ACK** (i.e. never dropped) is ignored until it falls.
- **Reset asserted mid-ACCESS:** `mem_we` drops immediately, because it is decoded from state. No partial ack is issued.
- **CPU memory requests** made while `cpu_hold`=1 are not serviced. The CPU is frozen, so it re-presents them after release.

## Structure

- **Shared package `cpu_pkg`:** `DATA_W`=16, `ADDR_W`=16, and the `dbg_state_t` enum {IDLE, WAIT_BND, ACCESS, WAIT_DATA, ACK}.
- **Sub-module `hold_timeout_counter`:** parameterised saturating counter with `clear`, `en` and `expired` ports, reused for the WAIT_DATA latency count.

## Test plan

1. CPU at boundary; debug write 0xA107 to 0x000E -> `mem_we` high for 1 cycle with `mem_addr`=0x000E; `dbg_ack` 2 edges later; `cpu_hold` high throughout.
2. Debug read of 0x000E after test 1, `MEM_LATENCY`=1 -> `dbg_rdata`=0xA107 with `dbg_ack` 3 edges after request; `dbg_err`=0.
3. CPU mid-instruction, boundary arrives 3 cycles after `dbg_req` -> WAIT_BND for 3 cycles with `cpu_hold`=0; on the boundary the hold asserts the same cycle and the CPU PC stays unchanged through the access.
4. `TIMEOUT`=8, `cpu_boundary` tied 0 -> `dbg_ack`=1, `dbg_err`=1 after 8 WAIT_BND cycles; no `mem_we`; `cpu_hold` never asserted.
5. `reset` low during ACCESS of a write -> `mem_we` drops immediately; all outputs at reset values; no ack after `reset` returns high.
6. `dbg_req` dropped after 2 cycles in WAIT_BND -> returns to IDLE, no ack; a subsequent request at a boundary completes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths and debug arbiter state encoding
package cpu_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BND,
    ACCESS,
    WAIT_DATA,
    ACK
  } dbg_state_t;
endpackage

// File: rtl/hold_timeout_counter.sv
// rtl/hold_timeout_counter.sv - saturating cycle counter flagging LIMIT-1 reached
module hold_timeout_counter #(
  parameter int LIMIT = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en && (cnt_q != W'(LIMIT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q >= W'(LIMIT - 1));
endmodule

// File: rtl/mem_debug_arbiter.sv
// rtl/mem_debug_arbiter.sv - grants the memory port to debug accesses at CPU fetch boundaries
module mem_debug_arbiter
  import cpu_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int TIMEOUT     = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_boundary,
  input  logic [ADDR_W-1:0] cpu_mem_addr,
  input  logic [DATA_W-1:0] cpu_mem_wdata,
  input  logic              cpu_mem_we,
  output logic              cpu_hold,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic              dbg_err,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);
  dbg_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              we_q;
  logic              err_q, err_d;
  logic              latch_req;
  logic              to_expired;
  logic              lat_expired;
  logic              dbg_path;
  logic              grant_now;

  hold_timeout_counter #(.LIMIT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst_n   (reset),
    .clear   (state_q != WAIT_BND),
    .en      (state_q == WAIT_BND),
    .expired (to_expired)
  );

  hold_timeout_counter #(.LIMIT(MEM_LATENCY)) u_latency (
    .clk     (clk),
    .rst_n   (reset),
    .clear   (state_q != WAIT_DATA),
    .en      (state_q == WAIT_DATA),
    .expired (lat_expired)
  );

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    latch_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (dbg_req) begin
          if (cpu_boundary) begin
            latch_req = 1'b1;
            state_d   = ACCESS;
          end else begin
            state_d = WAIT_BND;
          end
        end
      end
      WAIT_BND: begin
        // An abandoned request must not be granted even if the boundary arrives together.
        if (!dbg_req) begin
          state_d = IDLE;
        end else if (cpu_boundary) begin
          latch_req = 1'b1;
          state_d   = ACCESS;
        end else if (to_expired) begin
          err_d   = 1'b1;
          state_d = ACK;
        end
      end
      ACCESS:    state_d = we_q ? ACK : WAIT_DATA;
      WAIT_DATA: if (lat_expired) state_d = ACK;
      ACK: begin
        if (!dbg_req) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (latch_req) begin
        addr_q  <= dbg_addr;
        wdata_q <= dbg_wdata;
        we_q    <= dbg_we;
      end
      if ((state_q == WAIT_DATA) && lat_expired) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  // A timeout ACK never owned the port, so the CPU keeps it.
  assign dbg_path  = (state_q == ACCESS) || (state_q == WAIT_DATA) ||
                     ((state_q == ACK) && !err_q);
  assign grant_now = dbg_req && cpu_boundary &&
                     ((state_q == IDLE) || (state_q == WAIT_BND));

  assign cpu_hold  = reset && (dbg_path || grant_now);
  assign mem_addr  = dbg_path ? addr_q  : cpu_mem_addr;
  assign mem_wdata = dbg_path ? wdata_q : cpu_mem_wdata;
  assign mem_we    = dbg_path ? ((state_q == ACCESS) && we_q) : cpu_mem_we;
  assign dbg_ack   = (state_q == ACK);
  assign dbg_err   = (state_q == ACK) && err_q;
  assign dbg_rdata = rdata_q;
endmodule
